alu_unit: RTL and testbench
===========================

ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active low.
REQ-004 SHALL have port en  input  1  capture enable for the registered outputs.
REQ-005 SHALL have port alu_op  input  3  operation class from the main decoder.
REQ-006 SHALL have port func3_code  input  3  instr[14:12].
REQ-007 SHALL have port func7_code  input  1  instr[30].
REQ-008 SHALL have port op_A  input  XLEN  first operand, already forwarded and muxed.
REQ-009 SHALL have port op_B  input  XLEN  second operand, already forwarded and muxed.
REQ-010 SHALL have port alu_ctrl  output  4  decoded ALU control, combinational.
REQ-011 SHALL have port alu_o  output  XLEN  result, combinational.
REQ-012 SHALL have port br_mark  output  1  branch-taken mark, combinational.
REQ-013 SHALL have port alu_o_q  output  XLEN  alu_o registered.
REQ-014 SHALL have port br_mark_q  output  1  br_mark registered.

Function
REQ-015 SHALL define the alu_op classes as:
- 000 ADD: load/store address, JAL, JALR, AUIPC.
- 001 BRANCH.
- 010 R-type.
- 011 I-type arithmetic.
- 100 LUI.
- 101..111 treated as ADD.
REQ-016 SHALL encode alu_ctrl as: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, BEQ A, BNE B, BLT C, BGE D, BLTU E, BGEU F.
REQ-017 SHALL decode R-type by func3:
- 000: SUB if func7_code=1, else ADD.
- 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
- 101: SRA if func7_code=1, else SRL.
- 110 OR, 111 AND.
REQ-018 SHALL decode I-type identically to R-type, except func3=000 is always ADD (func7_code ignored).
REQ-019 SHALL decode BRANCH by func3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 decode to BEQ with br_mark forced 0.
REQ-020 SHALL decode LUI as ADD; op_A is 0 upstream, so the result equals op_B.
REQ-021 SHALL compute ADD/SUB modulo 2^XLEN with no overflow flag.
REQ-022 SHALL use only op_B[4:0] as the shift amount; SRA replicates op_A[31].
REQ-023 SHALL make SLT/SLTU return 1 or 0 zero-extended, with signed and unsigned compare respectively.
REQ-024 SHALL drive alu_o to 0 for the compare codes A..F.
REQ-025 SHALL drive br_mark, for codes A..F, with the compare result (EQ, NE, signed LT, signed GE, unsigned LT, unsigned GE).
REQ-026 SHALL drive br_mark to 1 for codes 0..9, so that the downstream br_ctrl = br_mark AND ex_br gives unconditional JAL/JALR.
REQ-027 SHALL make alu_ctrl, alu_o and br_mark purely combinational with zero latency, with no latch inferred.
REQ-028 SHALL capture alu_o_q and br_mark_q from alu_o and br_mark at a rising clk edge with en=1, and hold them when en=0; latency is 1 cycle.

Reset
REQ-029 SHALL clear alu_o_q and br_mark_q to 0 immediately when rst_n goes low, independent of clk.
REQ-030 SHALL hold alu_o_q and br_mark_q at 0 while rst_n=0; capture resumes at the first rising edge with rst_n=1 and en=1.
REQ-031 SHALL keep the combinational outputs unaffected by rst_n; reset mid-operation only clears the registers.

Structure
REQ-032 SHALL place the alu_op class codes and alu_ctrl codes in the shared define/package file used by the pipeline stages.
REQ-033 SHALL contain one sub-module, alu_control (alu_op, func3_code, func7_code -> alu_ctrl), with the datapath and registers in alu_unit.

Verification
REQ-034 SHALL pass the R-type SUB check: alu_op=010, f3=000, f7=1, A=5, B=7 -> alu_ctrl=1, alu_o=FFFFFFFE, br_mark=1.
REQ-035 SHALL pass the I-type SRA check: alu_op=011, f3=101, f7=1, A=80000000, B=00000024 -> alu_o=F8000000 (shift amount 4).
REQ-036 SHALL pass the branch compare checks:
- alu_op=001, f3=100 (BLT), A=FFFFFFFF, B=1 -> br_mark=1, alu_o=0.
- Same operands with f3=110 (BLTU) -> br_mark=0.
REQ-037 SHALL pass the JAL check: alu_op=000, A=pc 00000100, B=4 -> alu_o=00000104, br_mark=1.
REQ-038 SHALL pass the register/reset check: en=1 with alu_o=1234 -> alu_o_q=1234 after one edge; en=0 holds; rst_n low between edges -> alu_o_q=0 immediately.
REQ-039 SHALL pass the illegal-branch check: alu_op=001, f3=010, A=B=3 -> br_mark=0.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// Shared ALU encodings: main-decoder operation classes and ALU control codes.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package alu_unit_pkg;

    // Operation class handed down by the main decoder.
    // Codes 101..111 are unused and execute as ADD.
    typedef enum logic [2:0] {
        ALU_OP_ADD    = 3'b000,  // address calc, JAL, JALR, AUIPC
        ALU_OP_BRANCH = 3'b001,
        ALU_OP_RTYPE  = 3'b010,
        ALU_OP_ITYPE  = 3'b011,
        ALU_OP_LUI    = 3'b100
    } alu_op_e;

    // Decoded ALU control. Codes 0..9 produce a result; A..F are compares
    // that only drive the branch mark.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLL  = 4'h2,
        ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_OR   = 4'h8,
        ALU_AND  = 4'h9,
        ALU_BEQ  = 4'hA,
        ALU_BNE  = 4'hB,
        ALU_BLT  = 4'hC,
        ALU_BGE  = 4'hD,
        ALU_BLTU = 4'hE,
        ALU_BGEU = 4'hF
    } alu_ctrl_e;

    localparam int unsigned ALU_SHAMT_W = 5;

    // True for the compare codes A..F.
    function automatic logic is_cmp(input logic [3:0] ctrl);
        return ctrl[3] & (ctrl[2] | ctrl[1]);
    endfunction

endpackage

// File: rtl/alu_unit_alu_control.sv
// ALU control decode: (alu_op, func3, func7) -> 4-bit ALU control code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module alu_control
    import alu_unit_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [2:0] func3_code,
    input  logic       func7_code,
    output logic [3:0] alu_ctrl,
    // Set for the reserved branch func3 codes 010/011; the datapath must
    // then suppress the branch mark even though the code decodes to BEQ.
    output logic       br_illegal
);

    // Decode the operation class and function fields into a control code.
    always_comb begin
        alu_ctrl   = ALU_ADD;
        br_illegal = 1'b0;
        case (alu_op)
            ALU_OP_BRANCH: begin
                case (func3_code)
                    3'b000:  alu_ctrl = ALU_BEQ;
                    3'b001:  alu_ctrl = ALU_BNE;
                    3'b100:  alu_ctrl = ALU_BLT;
                    3'b101:  alu_ctrl = ALU_BGE;
                    3'b110:  alu_ctrl = ALU_BLTU;
                    3'b111:  alu_ctrl = ALU_BGEU;
                    default: begin
                        alu_ctrl   = ALU_BEQ;
                        br_illegal = 1'b1;
                    end
                endcase
            end
            ALU_OP_RTYPE, ALU_OP_ITYPE: begin
                case (func3_code)
                    // Immediate forms have no SUB; instr[30] is immediate data there.
                    3'b000:  alu_ctrl = (alu_op == ALU_OP_RTYPE && func7_code) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = func7_code ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            // ADD class, LUI (op_A is zero upstream) and unused classes all add.
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// Execute-stage ALU: decode, combinational result/branch mark, plus registered copies.
// Latency: alu_o/br_mark zero cycles; alu_o_q/br_mark_q one cycle after an en=1 edge.
// Backpressure: none; en=0 holds the registered outputs, combinational outputs always follow.
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [2:0]      alu_op,
    input  logic [2:0]      func3_code,
    input  logic            func7_code,
    input  logic [XLEN-1:0] op_A,
    input  logic [XLEN-1:0] op_B,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_o,
    output logic            br_mark,
    output logic [XLEN-1:0] alu_o_q,
    output logic            br_mark_q
);

    logic                   br_illegal;
    logic [ALU_SHAMT_W-1:0] shamt;
    logic                   lt_s;
    logic                   lt_u;
    logic                   eq;
    logic [XLEN-1:0]        alu_o_d;
    logic                   br_mark_d;

    alu_control u_alu_control (
        .alu_op     (alu_op),
        .func3_code (func3_code),
        .func7_code (func7_code),
        .alu_ctrl   (alu_ctrl),
        .br_illegal (br_illegal)
    );

    assign shamt = op_B[ALU_SHAMT_W-1:0];
    assign lt_s  = $signed(op_A) < $signed(op_B);
    assign lt_u  = op_A < op_B;
    assign eq    = op_A == op_B;

    // Result and branch mark; non-compare ops mark taken so JAL/JALR branch unconditionally.
    always_comb begin
        alu_o   = '0;
        br_mark = 1'b1;
        case (alu_ctrl_e'(alu_ctrl))
            ALU_ADD:  alu_o = op_A + op_B;
            ALU_SUB:  alu_o = op_A - op_B;
            ALU_SLL:  alu_o = op_A << shamt;
            ALU_SLT:  alu_o = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: alu_o = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  alu_o = op_A ^ op_B;
            ALU_SRL:  alu_o = op_A >> shamt;
            ALU_SRA:  alu_o = $unsigned($signed(op_A) >>> shamt);
            ALU_OR:   alu_o = op_A | op_B;
            ALU_AND:  alu_o = op_A & op_B;
            ALU_BEQ:  br_mark = eq & ~br_illegal;
            ALU_BNE:  br_mark = ~eq;
            ALU_BLT:  br_mark = lt_s;
            ALU_BGE:  br_mark = ~lt_s;
            ALU_BLTU: br_mark = lt_u;
            ALU_BGEU: br_mark = ~lt_u;
        endcase
    end

    // Next-state for the output registers: capture on en, otherwise hold.
    always_comb begin
        alu_o_d   = en ? alu_o   : alu_o_q;
        br_mark_d = en ? br_mark : br_mark_q;
    end

    // Output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_o_q   <= '0;
            br_mark_q <= 1'b0;
        end else begin
            alu_o_q   <= alu_o_d;
            br_mark_q <= br_mark_d;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: hand-computed vectors for decode, datapath, branch marks and registers.
// Latency: checks combinational outputs #1 after input change, registered outputs #1 after the edge.
// Backpressure: n/a.
module tb_alu_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  alu_op;
    logic [2:0]  func3_code;
    logic        func7_code;
    logic [31:0] op_A;
    logic [31:0] op_B;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_o;
    logic        br_mark;
    logic [31:0] alu_o_q;
    logic        br_mark_q;

    int n_cmp;
    int n_bad;

    alu_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .alu_op     (alu_op),
        .func3_code (func3_code),
        .func7_code (func7_code),
        .op_A       (op_A),
        .op_B       (op_B),
        .alu_ctrl   (alu_ctrl),
        .alu_o      (alu_o),
        .br_mark    (br_mark),
        .alu_o_q    (alu_o_q),
        .br_mark_q  (br_mark_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic vec(input string tag, input logic [2:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] e_ctrl, input logic [31:0] e_o, input logic e_br);
        alu_op     = op;
        func3_code = f3;
        func7_code = f7;
        op_A       = a;
        op_B       = b;
        #1;
        chk({tag, ".ctrl"}, {28'h0, alu_ctrl}, {28'h0, e_ctrl});
        chk({tag, ".o"},    alu_o, e_o);
        chk({tag, ".br"},   {31'h0, br_mark}, {31'h0, e_br});
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        alu_op     = 3'b000;
        func3_code = 3'b000;
        func7_code = 1'b0;
        op_A       = 32'h0;
        op_B       = 32'h0;
        #2;
        chk("rst.alu_o_q",   alu_o_q, 32'h0);
        chk("rst.br_mark_q", {31'h0, br_mark_q}, 32'h0);
        // Combinational path is live during reset.
        vec("rst.comb", 3'b000, 3'b000, 1'b0, 32'h2, 32'h3, 4'h0, 32'h5, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;

        // R-type / I-type arithmetic and logic.
        vec("sub",    3'b010, 3'b000, 1'b1, 32'h5,        32'h7,        4'h1, 32'hFFFFFFFE, 1'b1);
        vec("add",    3'b010, 3'b000, 1'b0, 32'h5,        32'h7,        4'h0, 32'h0000000C, 1'b1);
        vec("sll",    3'b010, 3'b001, 1'b0, 32'h1,        32'h23,       4'h2, 32'h00000008, 1'b1);
        vec("slt",    3'b010, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h1,        4'h3, 32'h00000001, 1'b1);
        vec("slt.n",  3'b010, 3'b010, 1'b0, 32'h1,        32'hFFFFFFFF, 4'h3, 32'h00000000, 1'b1);
        vec("sltu",   3'b010, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h1,        4'h4, 32'h00000000, 1'b1);
        vec("xor",    3'b010, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'h5, 32'h0FF00FF0, 1'b1);
        vec("srl",    3'b010, 3'b101, 1'b0, 32'h80000000, 32'h4,        4'h6, 32'h08000000, 1'b1);
        vec("srai",   3'b011, 3'b101, 1'b1, 32'h80000000, 32'h24,       4'h7, 32'hF8000000, 1'b1);
        vec("ori",    3'b011, 3'b110, 1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 4'h8, 32'hFFFFF0F0, 1'b1);
        vec("and",    3'b010, 3'b111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'h9, 32'hF000F000, 1'b1);
        vec("addi.f7",3'b011, 3'b000, 1'b1, 32'h5,        32'h7,        4'h0, 32'h0000000C, 1'b1);
        vec("add.wrap",3'b010,3'b000, 1'b0, 32'hFFFFFFFF, 32'h2,        4'h0, 32'h00000001, 1'b1);

        // Branch compares.
        vec("beq",    3'b001, 3'b000, 1'b0, 32'h3,        32'h3,        4'hA, 32'h0, 1'b1);
        vec("bne",    3'b001, 3'b001, 1'b0, 32'h3,        32'h3,        4'hB, 32'h0, 1'b0);
        vec("blt",    3'b001, 3'b100, 1'b0, 32'hFFFFFFFF, 32'h1,        4'hC, 32'h0, 1'b1);
        vec("bge",    3'b001, 3'b101, 1'b0, 32'hFFFFFFFF, 32'h1,        4'hD, 32'h0, 1'b0);
        vec("bltu",   3'b001, 3'b110, 1'b0, 32'hFFFFFFFF, 32'h1,        4'hE, 32'h0, 1'b0);
        vec("bgeu",   3'b001, 3'b111, 1'b0, 32'hFFFFFFFF, 32'h1,        4'hF, 32'h0, 1'b1);
        vec("br.ill2",3'b001, 3'b010, 1'b0, 32'h3,        32'h3,        4'hA, 32'h0, 1'b0);
        vec("br.ill3",3'b001, 3'b011, 1'b1, 32'h3,        32'h3,        4'hA, 32'h0, 1'b0);

        // ADD-class users.
        vec("lui",    3'b100, 3'b101, 1'b1, 32'h0,        32'h12345000, 4'h0, 32'h12345000, 1'b1);
        vec("jal",    3'b000, 3'b000, 1'b0, 32'h00000100, 32'h4,        4'h0, 32'h00000104, 1'b1);
        vec("op111",  3'b111, 3'b001, 1'b1, 32'h2,        32'h3,        4'h0, 32'h00000005, 1'b1);

        // Registered outputs: capture, hold, async clear, hold in reset, resume.
        en = 1'b1;
        vec("reg.in", 3'b000, 3'b000, 1'b0, 32'h1000,     32'h234,      4'h0, 32'h1234, 1'b1);
        @(posedge clk); #1;
        chk("reg.cap.o",  alu_o_q, 32'h1234);
        chk("reg.cap.br", {31'h0, br_mark_q}, 32'h1);
        en = 1'b0;
        vec("reg.in2",3'b001, 3'b001, 1'b0, 32'h3,        32'h3,        4'hB, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("reg.hold.o",  alu_o_q, 32'h1234);
        chk("reg.hold.br", {31'h0, br_mark_q}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reg.arst.o",  alu_o_q, 32'h0);
        chk("reg.arst.br", {31'h0, br_mark_q}, 32'h0);
        en = 1'b1;
        vec("reg.in3",3'b000, 3'b000, 1'b0, 32'h50,       32'h5,        4'h0, 32'h55, 1'b1);
        @(posedge clk); #1;
        chk("reg.inrst.o", alu_o_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reg.resume.o",  alu_o_q, 32'h55);
        chk("reg.resume.br", {31'h0, br_mark_q}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
